icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
Direct-mapped instruction cache that answers the fetch PC and produces the instruction word plus icache_stall for the pipeline PC register.
- Hit: instruction returned combinationally in the same cycle, no stall.
- Miss: asserts icache_stall and refills the whole line from instruction memory with a word-by-word req/ack handshake, then resumes.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
- NUM_LINES, 64, number of lines; power of two.
- NOP_INSTR, 32'h00000013, value driven on instr when no valid instruction is available.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fetch_en  in  1  pc is a valid fetch request this cycle
- pc  in  32  fetch address; bits [1:0] ignored
- flush  in  1  one-cycle pulse; invalidate all lines (fence.i)
- instr  out  32  fetched instruction
- icache_stall  out  1  fetch not satisfied; PC must hold
- mem_req  out  1  memory word request
- mem_addr  out  32  word-aligned request address
- mem_ack  in  1  memory word returned this cycle
- mem_rdata  in  32  returned word, valid when mem_ack=1

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WORDS), IDX_W = log2(NUM_LINES).
  - offset = pc[OFF_W+1:2]; index = pc[IDX_W+OFF_W+1:OFF_W+2]; tag = remaining upper bits.
- Storage:
  - Per line: valid bit, tag, LINE_WORDS data words.
  - Data is asynchronously readable (register array).
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE:
  - hit = fetch_en & valid[index] & (tag_store[index]==tag).
  - On hit: instr = data[index][offset], icache_stall = 0.
  - On fetch_en & !hit: icache_stall = 1 combinationally in the same cycle; instr = NOP_INSTR.
  - At that clock edge: latch miss line base (pc with offset and byte bits cleared), clear word counter, go to REFILL.
  - fetch_en = 0: icache_stall = 0, instr = NOP_INSTR.
- REFILL:
  - mem_req = 1; mem_addr = base + 4*cnt.
  - Each cycle with mem_ack = 1: write mem_rdata into data[idx][cnt], cnt++.
  - On the ack with cnt = LINE_WORDS-1: write tag, set valid, go to FILL_DONE.
  - mem_addr and mem_req are held stable between acks.
  - mem_ack while mem_req = 0 is ignored.
- FILL_DONE:
  - One cycle, icache_stall = 1, mem_req = 0; then IDLE.
  - The following cycle re-looks-up pc and hits.
- icache_stall = 1 throughout REFILL and FILL_DONE. pc is stable while stalled; the refill uses the latched base regardless.
- Miss penalty: sum of ack latencies + 2 cycles.
- flush:
  - In IDLE: all valid bits cleared at the edge; the lookup in that same cycle is treated as a miss.
  - In REFILL/FILL_DONE: flush is latched as pending and applied on return to IDLE, which also invalidates the just-filled line.
- Reset (any time, including mid-refill):
  - All valid bits = 0, FSM = IDLE, cnt = 0, flush pending = 0, mem_req = 0, mem_addr = 0.
  - Outputs: icache_stall = 0, instr = NOP_INSTR while fetch_en = 0.
  - Data and tag arrays need not reset.
- Address wrap: a line base of 0xFFFFFFF0 with LINE_WORDS = 4 addresses words up to 0xFFFFFFFC; no carry out.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined: adds outputs perf_hits [31:0] and perf_misses [31:0].
  - Counts each IDLE cycle with fetch_en & hit, and each miss entry into REFILL respectively.
  - Reset to 0; saturate at 32'hFFFFFFFF; unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - FSM state enum (IDLE, REFILL, FILL_DONE).
  - NOP_INSTR constant.
  - Functions computing OFF_W, IDX_W and TAG_W from the parameters.
- One natural sub-module, icache_tag_array:
  - Holds valid and tag storage with the hit compare.
  - Takes a flush-all input.
- Data array and FSM stay in icache_dm.

Test Plan:
1. Reset, fetch_en=1, pc=0x100, mem_ack after 2 cycles per word -> icache_stall=1 same cycle; mem_addr sequence 0x100, 0x104, 0x108, 0x10C; stall low on cycle 2 after last ack; instr = word0.
2. After test 1, pc=0x104, 0x108, 0x10C on consecutive cycles -> icache_stall=0 each cycle; instr = words 1..3, zero-cycle latency.
3. pc=0x100, then 0x500 (same index, NUM_LINES=64, LINE_WORDS=4) -> miss, refill from 0x500; then pc=0x100 -> miss again (conflict eviction).
4. Flush pulse during a refill of 0x200 -> refill completes; next fetch of 0x200 misses again; earlier-cached 0x100 also misses.
5. rst asserted after second ack of a refill -> mem_req=0 immediately; after release pc=0x100 misses and refill restarts at 0x100.
6. ICACHE_PERF_EN defined, sequence of tests 1+2 -> perf_misses=1, perf_hits=4 (including the post-refill hit of 0x100).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL    = 2'd1,
      FILL_DONE = 2'd2
   } icache_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic int unsigned off_w(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned idx_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   // Byte-offset bits [1:0] are never part of the tag.
   function automatic int unsigned tag_w(input int unsigned line_words,
                                         input int unsigned num_lines);
      return 32 - 2 - off_w(line_words) - idx_w(num_lines);
   endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tag store for the direct-mapped cache, with combinational hit compare
// and a single-cycle invalidate-all.
module icache_tag_array
   import icache_pkg::*;
#(
   parameter int unsigned NUM_LINES = 64,
   parameter int unsigned IDX_W     = 6,
   parameter int unsigned TAG_W     = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lookup_idx,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             hit_c,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             flush_all
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_mem [NUM_LINES];

   // Invalidate-all wins over a same-edge fill so a pending flush also drops that line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx] <= wr_tag;
      end
   end

   assign hit_c = valid_q[lookup_idx] & (tag_mem[lookup_idx] == lookup_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, whole-line refill over a req/ack port.
// Optional perf_hits/perf_misses counters are built when ICACHE_PERF_EN is defined.
module icache_dm #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned NUM_LINES  = 64,
   parameter logic [31:0] NOP_INSTR  = icache_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic [31:0] instr,
   output logic        icache_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses
`endif
);

   import icache_pkg::*;

   localparam int unsigned OFF_W  = off_w(LINE_WORDS);
   localparam int unsigned IDX_W  = idx_w(NUM_LINES);
   localparam int unsigned TAG_W  = tag_w(LINE_WORDS, NUM_LINES);
   localparam int unsigned BASE_W = OFF_W + 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   icache_state_e    state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             tag_hit_c;
   logic             hit;
   logic             fill_we;
   logic             tag_we;
   logic             flush_all;
   logic [1:0]       unused_pc_bits;

   logic [31:0] data_mem [NUM_LINES][LINE_WORDS];

   assign pc_off         = pc[OFF_W+1:2];
   assign pc_idx         = pc[IDX_W+OFF_W+1:OFF_W+2];
   assign pc_tag         = pc[31:IDX_W+OFF_W+2];
   assign fill_idx       = base_q[IDX_W+OFF_W+1:OFF_W+2];
   assign fill_tag       = base_q[31:IDX_W+OFF_W+2];
   assign unused_pc_bits = pc[1:0];

   icache_tag_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_tags (
      .clk        (clk),
      .rst        (rst),
      .lookup_idx (pc_idx),
      .lookup_tag (pc_tag),
      .hit_c      (tag_hit_c),
      .wr_en      (tag_we),
      .wr_idx     (fill_idx),
      .wr_tag     (fill_tag),
      .flush_all  (flush_all)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state and pipeline-facing outputs; hit/stall/instr are same-cycle by design.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      instr        = NOP_INSTR;
      icache_stall = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      hit          = 1'b0;
      fill_we      = 1'b0;
      tag_we       = 1'b0;
      flush_all    = 1'b0;
      unique case (state_q)
         IDLE: begin
            flush_all = flush;
            hit       = fetch_en & tag_hit_c & ~flush;
            if (hit) begin
               instr = data_mem[pc_idx][pc_off];
            end else if (fetch_en) begin
               icache_stall = 1'b1;
               base_d       = {pc[31:BASE_W], BASE_W'(0)};
               cnt_d        = '0;
               state_d      = REFILL;
            end
         end
         REFILL: begin
            icache_stall = 1'b1;
            mem_req      = 1'b1;
            mem_addr     = base_q + 32'({cnt_q, 2'b00});
            if (flush) begin
               pend_d = 1'b1;
            end
            if (mem_ack) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + OFF_W'(1);
               if (cnt_q == LAST_WORD) begin
                  tag_we  = 1'b1;
                  state_d = FILL_DONE;
               end
            end
         end
         FILL_DONE: begin
            icache_stall = 1'b1;
            flush_all    = pend_q | flush;
            pend_d       = 1'b0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[fill_idx][cnt_q] <= mem_rdata;
      end
   end

`ifdef ICACHE_PERF_EN
   logic perf_miss;

   assign perf_miss = (state_q == IDLE) & fetch_en & ~hit;

   // Saturating event counters; flush does not touch them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_hits   <= '0;
         perf_misses <= '0;
      end else begin
         if (hit && (perf_hits != 32'hFFFF_FFFF)) begin
            perf_hits <= perf_hits + 32'd1;
         end
         if (perf_miss && (perf_misses != 32'hFFFF_FFFF)) begin
            perf_misses <= perf_misses + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm against a transaction-level cache model and a
// hashed instruction memory with random ack latency.
module tb_icache_dm;

   localparam int unsigned LW   = 4;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] pc;
   logic        flush;
   logic [31:0] instr;
   logic        icache_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;
`endif

   int checks = 0;
   int failures = 0;

   logic [63:0] ref_valid;
   logic [21:0] ref_tag [64];
   int          nhits;
   int          nmiss;

   int          lat_lo;
   int          lat_hi;
   logic [31:0] addr_log[$];
   int          lat_log[$];

   icache_dm dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_en     (fetch_en),
      .pc           (pc),
      .flush        (flush),
      .instr        (instr),
      .icache_stall (icache_stall),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata)
`ifdef ICACHE_PERF_EN
      ,
      .perf_hits    (perf_hits),
      .perf_misses  (perf_misses)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_perf();
`ifdef ICACHE_PERF_EN
      check("perf_hits", perf_hits, 32'(nhits));
      check("perf_misses", perf_misses, 32'(nmiss));
`endif
   endtask

   // Memory responder: random ack delay per word, spurious acks while no request.
   initial begin
      int wl;
      int cur_lat;
      wl = -1;
      cur_lat = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (wl < 0) begin
               wl = int'($urandom_range(lat_hi, lat_lo));
               cur_lat = wl + 1;
            end
            if (wl == 0) begin
               mem_ack = 1'b1;
               mem_rdata = mem_word(mem_addr);
               addr_log.push_back(mem_addr);
               lat_log.push_back(cur_lat);
               wl = -1;
            end else begin
               wl--;
            end
         end else begin
            wl = -1;
            if ($urandom_range(3, 0) == 0) begin
               mem_ack = 1'b1;
               mem_rdata = $urandom;
            end
         end
      end
   end

   task automatic idle_cycle(input logic fl);
      @(posedge clk); #1;
      fetch_en = 1'b0;
      flush = fl;
      @(negedge clk); #1;
      check("idle_stall", 32'(icache_stall), 32'd0);
      check("idle_instr", instr, NOP);
      check("idle_req", 32'(mem_req), 32'd0);
      if (fl) ref_valid = '0;
   endtask

   // One fetch transaction: lookup, and on a miss follow the whole refill to the re-lookup.
   task automatic do_fetch(input logic [31:0] a, input logic fl, input logic fl_mid);
      int          idx;
      logic [21:0] tg;
      logic [31:0] base;
      logic        exp_hit;
      logic        pend;
      int          n;
      int          bad;
      int          lat_sum;
      idx  = int'(a[9:4]);
      tg   = a[31:10];
      base = {a[31:4], 4'h0};
      @(posedge clk); #1;
      fetch_en = 1'b1;
      pc = a;
      flush = fl;
      addr_log.delete();
      lat_log.delete();
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tg) && !fl;
      @(negedge clk); #1;
      check("lookup_stall", 32'(icache_stall), 32'(!exp_hit));
      check("lookup_instr", instr, exp_hit ? mem_word({a[31:2], 2'b00}) : NOP);
      if (fl) ref_valid = '0;
      if (exp_hit) begin
         nhits++;
         return;
      end
      nmiss++;
      pend = 1'b0;
      n = 1;
      bad = 0;
      while (lat_log.size() < LW) begin
         @(posedge clk); #1;
         flush = fl_mid && (n == 1);
         if (flush) pend = 1'b1;
         @(negedge clk); #1;
         if (icache_stall !== 1'b1 || mem_req !== 1'b1) bad++;
         n++;
         if (n > 400) begin
            check("refill_timeout", 32'(n), 32'd0);
            break;
         end
      end
      check("refill_stall", 32'(bad), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk); #1;
      check("done_stall_req", {30'd0, icache_stall, mem_req}, 32'd2);
      n++;
      lat_sum = 0;
      foreach (lat_log[k]) lat_sum += lat_log[k];
      check("miss_penalty", 32'(n), 32'(lat_sum + 2));
      check("refill_words", 32'(addr_log.size()), 32'(LW));
      foreach (addr_log[k]) check("refill_addr", addr_log[k], base + 32'(4 * k));
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
      if (pend) ref_valid = '0;
      @(posedge clk); #1;
      if (pend) fetch_en = 1'b0;
      @(negedge clk); #1;
      check("relookup_stall", 32'(icache_stall), 32'd0);
      if (pend) begin
         check("relookup_instr", instr, NOP);
      end else begin
         check("relookup_instr", instr, mem_word({a[31:2], 2'b00}));
         nhits++;
      end
   endtask

   // Start a refill and assert reset right after its second word is accepted.
   task automatic reset_mid_refill(input logic [31:0] a);
      int guard;
      @(posedge clk); #1;
      fetch_en = 1'b1;
      pc = a;
      flush = 1'b0;
      addr_log.delete();
      lat_log.delete();
      guard = 0;
      while (lat_log.size() < 2 && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      check("rst_mid_reached", 32'(lat_log.size() >= 2), 32'd1);
      @(posedge clk); #1;
      fetch_en = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(mem_req), 32'd0);
      check("rst_mid_addr", mem_addr, 32'd0);
      check("rst_mid_stall", 32'(icache_stall), 32'd0);
      check("rst_mid_instr", instr, NOP);
      ref_valid = '0;
      nhits = 0;
      nmiss = 0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int r;
      rst = 1'b1;
      fetch_en = 1'b0;
      pc = '0;
      flush = 1'b0;
      ref_valid = '0;
      nhits = 0;
      nmiss = 0;
      lat_lo = 1;
      lat_hi = 1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_stall", 32'(icache_stall), 32'd0);
      check("reset_instr", instr, NOP);
      check("reset_req", 32'(mem_req), 32'd0);
      check("reset_addr", mem_addr, 32'd0);
      check_perf();
      rst = 1'b0;

      // Cold miss with 2-cycle acks, then consecutive same-line hits.
      do_fetch(32'h0000_0100, 1'b0, 1'b0);
      do_fetch(32'h0000_0104, 1'b0, 1'b0);
      do_fetch(32'h0000_0108, 1'b0, 1'b0);
      do_fetch(32'h0000_010C, 1'b0, 1'b0);
      check_perf();

      // Conflict eviction on the same index.
      do_fetch(32'h0000_0100, 1'b0, 1'b0);
      do_fetch(32'h0000_0500, 1'b0, 1'b0);
      do_fetch(32'h0000_0100, 1'b0, 1'b0);

      // Flush during a refill, then flush in IDLE with and without a fetch.
      do_fetch(32'h0000_0200, 1'b0, 1'b1);
      do_fetch(32'h0000_0200, 1'b0, 1'b0);
      do_fetch(32'h0000_0100, 1'b0, 1'b0);
      do_fetch(32'h0000_0100, 1'b1, 1'b0);
      idle_cycle(1'b1);
      do_fetch(32'h0000_0204, 1'b0, 1'b0);

      // Top-of-address-space line.
      do_fetch(32'hFFFF_FFF8, 1'b0, 1'b0);
      do_fetch(32'hFFFF_FFF0, 1'b0, 1'b0);
      check_perf();

      reset_mid_refill(32'h0000_0300);
      do_fetch(32'h0000_0100, 1'b0, 1'b0);

      lat_lo = 0;
      lat_hi = 3;
      for (int i = 0; i < 150; i++) begin
         a = {20'h0, 2'($urandom_range(3, 0)), 2'b00, 3'($urandom_range(7, 0)),
              2'($urandom_range(3, 0)), 2'b00};
         r = int'($urandom_range(19, 0));
         if (r == 0) idle_cycle(1'b1);
         else if (r == 1) do_fetch(a, 1'b1, 1'b0);
         else if (r == 2) do_fetch(a, 1'b0, 1'b1);
         else if (r == 3) idle_cycle(1'b0);
         else do_fetch(a, 1'b0, 1'b0);
      end
      check_perf();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
